// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART serial transmitter with configurable baud, data bits,
//            parity and stop bits. Reports busy/free status events.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int BAUD_DIV_WIDTH = 16,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [BAUD_DIV_WIDTH-1:0] cfg_baud_div,
    input  logic [3:0]                cfg_data_bits,
    input  logic                      cfg_data_bits_error,
    input  logic                      cfg_parity_en,
    input  logic                      cfg_parity_odd,
    input  logic                      cfg_stop_bits,
    output logic                      txd,
    output logic                      busy,
    output logic                      busy_pulse,
    output logic                      free_pulse
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]                r_state;
    logic [BAUD_DIV_WIDTH-1:0] r_baud_cnt;
    logic [3:0]                r_bit_cnt;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [BAUD_DIV_WIDTH-1:0] r_div;
    logic [3:0]                r_nbits;
    logic                      r_par_en;
    logic                      r_par_bit;
    logic                      r_stop2;

    logic [2:0]                w_state_next;
    logic [BAUD_DIV_WIDTH-1:0] w_baud_next;
    logic [3:0]                w_bit_next;
    logic [DATA_WIDTH-1:0]     w_shift_next;
    logic [DATA_WIDTH-1:0]     w_mask;
    logic                      w_bit_end;
    logic                      w_load;
    logic                      w_txd_next;
    logic                      w_busy_next;
    logic                      w_busy_pulse_next;
    logic                      w_free_pulse_next;

    assign tx_ready = (r_state == S_IDLE) & ~cfg_data_bits_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_div      <= '0;
            r_nbits    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            busy_pulse <= 1'b0;
            free_pulse <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            // Frame configuration is frozen at acceptance
            if (w_load) begin
                r_div     <= cfg_baud_div;
                r_nbits   <= cfg_data_bits;
                r_par_en  <= cfg_parity_en;
                r_par_bit <= (^(tx_data & w_mask)) ^ cfg_parity_odd;
                r_stop2   <= cfg_stop_bits;
            end
            txd        <= w_txd_next;
            busy       <= w_busy_next;
            busy_pulse <= w_busy_pulse_next;
            free_pulse <= w_free_pulse_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt + BAUD_DIV_WIDTH'(1);
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_load       = 1'b0;
        w_bit_end    = (r_baud_cnt == r_div);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_mask[i] = (i < int'(cfg_data_bits));
        end
        if (w_bit_end) begin
            w_baud_next = '0;
        end
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_bit_next  = '0;
                if (tx_valid && tx_ready) begin
                    w_load       = 1'b1;
                    w_shift_next = tx_data & w_mask;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == r_nbits - 4'd1) begin
                        w_bit_next   = '0;
                        w_state_next = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_bit_next   = '0;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == {3'b000, r_stop2}) begin
                        w_bit_next   = '0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_bit_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
            S_PARITY: w_txd_next = r_par_bit;
            default:  w_txd_next = 1'b1;
        endcase
        w_busy_next       = (w_state_next != S_IDLE);
        w_busy_pulse_next = (r_state == S_IDLE) && (w_state_next == S_START);
        w_free_pulse_next = (r_state == S_STOP) && (w_state_next == S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Randomized self-checking bench for uart_tx with a frame-level
//            reference model and literal frame patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
    localparam int BW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [BW-1:0] cfg_baud_div = '0;
    logic [3:0]    cfg_data_bits = 4'd8;
    logic          cfg_data_bits_error = 1'b0;
    logic          cfg_parity_en = 1'b0;
    logic          cfg_parity_odd = 1'b0;
    logic          cfg_stop_bits = 1'b0;
    logic          txd;
    logic          busy;
    logic          busy_pulse;
    logic          free_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx #(.BAUD_DIV_WIDTH(BW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cfg_baud_div(cfg_baud_div), .cfg_data_bits(cfg_data_bits),
        .cfg_data_bits_error(cfg_data_bits_error),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop_bits(cfg_stop_bits),
        .txd(txd), .busy(busy), .busy_pulse(busy_pulse), .free_pulse(free_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue entry per expected txd cycle of the frame
    logic mq[$];
    logic m_first = 1'b0;
    logic m_free  = 1'b0;

    function automatic void push_frame();
        logic bits[$];
        logic p;
        p = cfg_parity_odd;
        bits.push_back(1'b0);
        for (int i = 0; i < int'(cfg_data_bits); i++) begin
            bits.push_back(tx_data[i]);
            p = p ^ tx_data[i];
        end
        if (cfg_parity_en) bits.push_back(p);
        bits.push_back(1'b1);
        if (cfg_stop_bits) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r <= int'(cfg_baud_div); r++) mq.push_back(bits[k]);
        end
    endfunction

    always @(negedge clk) begin : model_cmp
        logic e_busy;
        logic e_txd;
        if (rst) begin
            mq.delete();
            m_first = 1'b0;
            m_free  = 1'b0;
        end
        e_busy = (mq.size() > 0);
        e_txd  = e_busy ? mq[0] : 1'b1;
        chk_b("txd", txd, e_txd);
        chk_b("busy", busy, e_busy);
        chk_b("busy_pulse", busy_pulse, m_first);
        chk_b("free_pulse", free_pulse, m_free);
        chk_b("tx_ready", tx_ready, !e_busy && !cfg_data_bits_error);
        m_first = 1'b0;
        m_free  = 1'b0;
        if (!rst) begin
            if (e_busy) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_free = 1'b1;
            end else if (tx_valid && !cfg_data_bits_error) begin
                push_frame();
                m_first = 1'b1;
            end
        end
    end

    task automatic wait_accept(input string nm);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!tx_ready && w < 200);
        chk_b({nm, "_ready"}, tx_ready, 1'b1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (busy && w < 5000);
        chk_b({nm, "_idle"}, busy, 1'b0);
    endtask

    // Sends one frame and checks it against a literal bit pattern (bit k = k-th bit on the line)
    task automatic send_lit(input logic [7:0] d, input logic [BW-1:0] dv, input logic [3:0] nb,
                            input logic pe, input logic po, input logic s2,
                            input logic [15:0] pat, input int nbits, input int ncyc,
                            input string nm);
        logic cap[$];
        int   w = 0;
        int   idx;
        @(posedge clk);
        #1;
        cfg_baud_div = dv; cfg_data_bits = nb; cfg_parity_en = pe;
        cfg_parity_odd = po; cfg_stop_bits = s2; tx_data = d; tx_valid = 1'b1;
        wait_accept(nm);
        @(negedge clk);
        chk_b({nm, "_bp_first"}, busy_pulse, 1'b1);
        while (busy && w < 4000) begin
            cap.push_back(txd);
            @(negedge clk);
            w++;
        end
        chk_b({nm, "_fp_end"}, free_pulse, 1'b1);
        chk_i({nm, "_len"}, cap.size(), ncyc);
        for (int k = 0; k < nbits; k++) begin
            idx = k * (int'(dv) + 1) + int'(dv) / 2;
            chk_b($sformatf("%s_bit%0d", nm, k), (idx < cap.size()) ? cap[idx] : 1'bx, pat[k]);
        end
    endtask

    initial begin
        int bad;
        int gap;
        int frames;
        logic acc;

        repeat (2) @(negedge clk);
        chk_b("reset_txd", txd, 1'b1);
        chk_b("reset_busy", busy, 1'b0);
        chk_b("reset_ready", tx_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        send_lit(8'h55, 16'd3, 4'd8, 1'b0, 1'b0, 1'b0, 16'h02AA, 10, 40, "f55_8n1");
        send_lit(8'h41, 16'd0, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0282, 10, 10, "f41_7e1");
        send_lit(8'hFF, 16'd1, 4'd5, 1'b1, 1'b1, 1'b1, 16'h01BE, 9, 18, "fff_5o2");

        // Illegal data-bits configuration blocks acceptance
        @(posedge clk);
        #1;
        cfg_data_bits_error = 1'b1; cfg_data_bits = 4'd9; tx_data = 8'h3C; tx_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_ready || !txd || busy_pulse || free_pulse || busy) bad++;
        end
        chk_i("err_blocked", bad, 0);
        @(posedge clk);
        #1 cfg_data_bits_error = 1'b0; cfg_data_bits = 4'd8; cfg_baud_div = 16'd0;
        @(negedge clk);
        chk_b("err_clear_ready", tx_ready, 1'b1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        chk_b("err_clear_start", busy_pulse, 1'b1);
        wait_idle("err_frame");

        // Config change mid-frame must not affect the frame in flight
        fork
            send_lit(8'h0F, 16'd3, 4'd8, 1'b0, 1'b0, 1'b0, 16'h021E, 10, 40, "f0f_mid");
            begin
                repeat (8) @(posedge clk);
                #1 cfg_baud_div = 16'd7; cfg_parity_en = 1'b1;
            end
        join
        send_lit(8'h00, 16'd7, 4'd8, 1'b1, 1'b0, 1'b0, 16'h0400, 11, 88, "f00_8e1");

        // Asynchronous reset in DATA bit 3
        @(posedge clk);
        #1;
        cfg_baud_div = 16'd3; cfg_data_bits = 4'd8; cfg_parity_en = 1'b0;
        cfg_stop_bits = 1'b0; tx_data = 8'hA5; tx_valid = 1'b1;
        wait_accept("rst_pre");
        repeat (17) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_b("rst_async_txd", txd, 1'b1);
        chk_b("rst_async_busy", busy, 1'b0);
        chk_b("rst_async_ready", tx_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        send_lit(8'hA5, 16'd3, 4'd8, 1'b0, 1'b0, 1'b0, 16'h034A, 10, 40, "fa5_post_rst");

        // Back-to-back frames with tx_valid held high
        @(posedge clk);
        #1;
        cfg_baud_div = 16'd1; cfg_data_bits = 4'd6; cfg_parity_en = 1'b0;
        cfg_stop_bits = 1'b0; tx_data = 8'($urandom); tx_valid = 1'b1;
        gap = 0; frames = 0;
        repeat (200) begin
            @(negedge clk);
            acc = tx_ready && tx_valid;
            if (busy_pulse) begin
                if (frames > 0) chk_i("b2b_gap", gap, 1);
                frames++;
                gap = 0;
            end else if (!busy) begin
                gap++;
            end
            @(posedge clk);
            #1 if (acc) tx_data = 8'($urandom);
        end
        tx_valid = 1'b0;
        chk_b("b2b_frames", frames > 8, 1'b1);
        wait_idle("b2b_end");

        // Randomized frames with mid-frame config and error churn
        for (int it = 0; it < 40; it++) begin
            @(posedge clk);
            #1;
            cfg_baud_div = 16'($urandom_range(0, 5));
            cfg_data_bits = 4'($urandom_range(5, 8));
            cfg_parity_en = 1'($urandom);
            cfg_parity_odd = 1'($urandom);
            cfg_stop_bits = 1'($urandom);
            tx_data = 8'($urandom);
            tx_valid = 1'b1;
            wait_accept("rnd");
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
            cfg_baud_div = 16'($urandom);
            cfg_data_bits = 4'($urandom_range(5, 8));
            cfg_parity_en = 1'($urandom);
            cfg_parity_odd = 1'($urandom);
            cfg_stop_bits = 1'($urandom);
            cfg_data_bits_error = ($urandom_range(0, 3) == 0);
            wait_idle("rnd");
            @(posedge clk);
            #1 cfg_data_bits_error = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter directly downstream of the UART control/status register block.
- Consumes the baud divisor and frame configuration from the baud-rate and control-0 registers, and serialises bytes from a valid/ready byte source onto txd.
- Returns busy/free event pulses that set and clear the busy flag in status-0.
- Blocks new frames while the register block reports a data-bits configuration error.

Parameters:
- BAUD_DIV_WIDTH, 16, width of the baud divisor; bit period = cfg_baud_div+1 clocks.
- DATA_WIDTH, 8, maximum data bits per frame; tx_data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- tx_data  input  DATA_WIDTH  byte to send, LSB transmitted first.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block accepts tx_data this cycle when tx_valid & tx_ready.
- cfg_baud_div  input  BAUD_DIV_WIDTH  bit period minus one, in clocks.
- cfg_data_bits  input  4  data bits per frame, legal 5..8.
- cfg_data_bits_error  input  1  data-bits configuration is illegal; blocks acceptance.
- cfg_parity_en  input  1  append a parity bit.
- cfg_parity_odd  input  1  1 = odd parity, 0 = even parity.
- cfg_stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- txd  output  1  serial line, idle high.
- busy  output  1  level, high from frame start through the last stop bit.
- busy_pulse  output  1  one-cycle pulse on the first start-bit cycle; sets status busy.
- free_pulse  output  1  one-cycle pulse on the first IDLE cycle after a frame; clears status busy.

Behaviour:
- Reset (async, immediate, including mid-frame):
  - txd=1, busy=0, busy_pulse=0, free_pulse=0, state IDLE, counters 0.
  - tx_ready follows IDLE & ~cfg_data_bits_error; after reset it is 1 unless error.
- tx_ready = (state==IDLE) & ~cfg_data_bits_error. Combinational from state and error only, never from tx_valid.
- Accept cycle T (tx_valid & tx_ready):
  - Latch tx_data, cfg_baud_div, cfg_data_bits, parity_en, parity_odd, stop_bits.
  - Config changes after T do not affect the frame in flight.
- State machine: IDLE -> START -> DATA -> PARITY (only if latched parity_en) -> STOP -> IDLE.
- Bit timing:
  - Baud counter counts 0..div; a bit ends on the cycle the counter equals div. The counter reloads to 0 at each bit boundary.
  - Every bit lasts exactly div+1 cycles; div=0 gives 1 cycle per bit.
- START: txd=0 from cycle T+1. busy=1 and busy_pulse=1 on T+1.
- DATA:
  - Bit counter 0..data_bits-1; txd = shift register LSB.
  - Shift right at each bit boundary.
- PARITY:
  - txd = XOR of the transmitted data bits only; bits above data_bits are masked.
  - The value is inverted when parity_odd=1.
- STOP: txd=1 for 1 or 2 bit periods. Exit to IDLE after the last stop bit.
- First IDLE cycle after STOP: busy=0, free_pulse=1, tx_ready=1 (if no error).
  - Minimum one-cycle gap between frames: a word accepted on the free_pulse cycle starts its start bit on the next cycle.
- Frame length in clocks: (1 + data_bits + parity_en + stop_count) * (div+1).
- Simultaneous events:
  - tx_valid while not ready: ignored, no latch; the source must hold tx_valid and tx_data.
  - cfg_data_bits_error asserting mid-frame: the current frame completes normally; only the next acceptance is blocked.
- busy_pulse and free_pulse are never high in the same cycle.
- All outputs are registered except tx_ready.

Test Plan:
- Reset, div=3, 8N1, tx_data=0x55 -> start 4 cycles low, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 stop high. busy high 40 cycles; busy_pulse at T+1; free_pulse at T+41.
- div=0, 7 data bits, even parity, 1 stop, tx_data=0x41 -> txd sequence 0,1,0,0,0,0,0,1,0,1 at one cycle per bit (parity 0); frame 10 cycles.
- div=1, 5 data bits, odd parity, 2 stop, tx_data=0xFF -> bits 1,1,1,1,1, parity 0, stop 1,1, 2 cycles each. Upper 3 data bits are never sent; frame 18 cycles.
- cfg_data_bits=9 with cfg_data_bits_error=1, tx_valid=1 -> tx_ready=0, txd stays 1, no pulses. Clearing error -> accepted next cycle.
- Mid-frame cfg_baud_div change from 3 to 7 and cfg_parity_en 0 to 1 -> the frame in flight keeps 4-cycle bits and no parity. The next frame uses 8-cycle bits with parity.
- rst asserted during DATA bit 3 -> txd=1, busy=0 immediately without a clock edge. After release, tx_ready=1 and a new 0xA5 frame transmits correctly. Back-to-back frames with tx_valid held high show exactly a one-cycle idle-high gap.
